// File: rtl/ps_mem_pkg.sv
// Shared types and default sizes for the ps_mem_responder memory/host sequencer.
package ps_mem_pkg;

  localparam int PS_ADDR_WIDTH = 8;
  localparam int PS_DATA_WIDTH = 16;
  localparam int PS_MEM_DEPTH  = 1 << PS_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_IM = 3'd1,
    ST_LOAD_DM = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DUMP    = 3'd5,
    ST_DONE    = 3'd6
  } ps_state_e;

endpackage

// File: rtl/ps_mem_responder_sync_ram.sv
// Single-port synchronous-read RAM; a same-cycle read and write returns the old word.
module sync_ram
  import ps_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = PS_ADDR_WIDTH,
  parameter int DATA_WIDTH = PS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Read register holds its value while re is low
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Array storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ps_mem_responder.sv
// Host load / run / drain / dump sequencer serving the processor IM and DM ports.
// Define PS_MEM_DUMP_EN to include the DM image dump; otherwise DRAIN ends in DONE.
module ps_mem_responder
  import ps_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = PS_ADDR_WIDTH,
  parameter int DATA_WIDTH   = PS_DATA_WIDTH,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_go,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_last,
  output logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  input  logic                  im_rd,
  output logic [DATA_WIDTH-1:0] im_r_data,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  done
);

  ps_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]           drain_q, drain_d;
  logic                  host_ready_q, host_ready_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  host_acc_s;
  logic                  im_we_s, im_re_s, dm_we_s, dm_re_s;
  logic [ADDR_WIDTH-1:0] im_addr_s, dm_addr_s;
  logic [DATA_WIDTH-1:0] dm_wdata_s, im_rdata_s, dm_rdata_s;

`ifdef PS_MEM_DUMP_EN
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic                  dvalid_q, dvalid_d;
  logic                  dlast_q, dlast_d;
  logic                  dm_own_q, dm_own_d;
  logic [DATA_WIDTH-1:0] dm_hold_q, dm_hold_d;
  logic                  issue_s;
  logic                  dump_fin_s;
`endif

  assign host_acc_s = host_valid && host_ready_q;

  // Next-state, load counter and drain counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (host_go) begin
          state_d = ST_LOAD_IM;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_IM, ST_LOAD_DM: begin
        if (host_acc_s && host_last) begin
          state_d = (state_q == ST_LOAD_IM) ? ST_LOAD_DM : ST_RUN;
          cnt_d   = '0;
        end else if (host_acc_s) begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
          drain_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 16'(DRAIN_CYCLES - 1)) begin
`ifdef PS_MEM_DUMP_EN
          state_d = ST_DUMP;
`else
          state_d = ST_DONE;
`endif
        end else begin
          drain_d = drain_q + 16'd1;
        end
      end
      ST_DUMP: begin
`ifdef PS_MEM_DUMP_EN
        if (dump_fin_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
`else
        state_d = ST_DONE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered status outputs decoded from the next state
  always_comb begin
    host_ready_d = (state_d == ST_LOAD_IM) || (state_d == ST_LOAD_DM);
    start_d      = (state_d == ST_RUN) && (state_q != ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  // RAM port ownership: host load, processor, or dump reader
  always_comb begin
    im_we_s    = 1'b0;
    im_re_s    = 1'b0;
    im_addr_s  = im_addr;
    dm_we_s    = 1'b0;
    dm_re_s    = 1'b0;
    dm_addr_s  = dm_addr;
    dm_wdata_s = dm_w_data;
    case (state_q)
      ST_LOAD_IM: begin
        im_we_s   = host_acc_s;
        im_addr_s = cnt_q;
      end
      ST_LOAD_DM: begin
        dm_we_s    = host_acc_s;
        dm_addr_s  = cnt_q;
        dm_wdata_s = host_data;
      end
      ST_RUN, ST_DRAIN: begin
        im_re_s = im_rd;
        dm_re_s = dm_rd;
        dm_we_s = dm_wr;
      end
      ST_DUMP: begin
`ifdef PS_MEM_DUMP_EN
        dm_re_s   = issue_s;
        dm_addr_s = ptr_q[ADDR_WIDTH-1:0];
`else
        dm_re_s   = 1'b0;
`endif
      end
      default: begin
        im_re_s = 1'b0;
      end
    endcase
  end

`ifdef PS_MEM_DUMP_EN
  // A new RAM read is issued only when the output word is free or leaving this cycle,
  // so the RAM read register itself holds dump_data stable under backpressure.
  always_comb begin
    issue_s    = (state_q == ST_DUMP) && !ptr_q[ADDR_WIDTH] && (!dvalid_q || dump_ready);
    dump_fin_s = dvalid_q && dump_ready && dlast_q;
    ptr_d      = ptr_q;
    dvalid_d   = dvalid_q && !dump_ready;
    dlast_d    = dlast_q;
    if (state_q != ST_DUMP) begin
      ptr_d = '0;
    end else if (issue_s) begin
      ptr_d = ptr_q + (ADDR_WIDTH + 1)'(1);
    end else begin
      ptr_d = ptr_q;
    end
    if (issue_s) begin
      dvalid_d = 1'b1;
      dlast_d  = (ptr_q == {1'b0, {ADDR_WIDTH{1'b1}}});
    end else if (dvalid_q && dump_ready) begin
      dlast_d = 1'b0;
    end else begin
      dlast_d = dlast_q;
    end
  end

  // Keep the processor's last DM read visible while the dump reuses the read register
  always_comb begin
    dm_own_d  = dm_own_q;
    dm_hold_d = dm_hold_q;
    if (issue_s) begin
      dm_own_d  = 1'b0;
      dm_hold_d = dm_own_q ? dm_rdata_s : dm_hold_q;
    end else if (dm_re_s) begin
      dm_own_d = 1'b1;
    end else begin
      dm_own_d = dm_own_q;
    end
  end

  // Dump pointer and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      dvalid_q  <= 1'b0;
      dlast_q   <= 1'b0;
      dm_own_q  <= 1'b1;
      dm_hold_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      dvalid_q  <= dvalid_d;
      dlast_q   <= dlast_d;
      dm_own_q  <= dm_own_d;
      dm_hold_q <= dm_hold_d;
    end
  end

  assign dump_valid = dvalid_q;
  assign dump_last  = dlast_q;
  assign dump_data  = dvalid_q ? dm_rdata_s : '0;
  assign dm_r_data  = dm_own_q ? dm_rdata_s : dm_hold_q;
`else
  logic dump_ready_unused_s;
  assign dump_ready_unused_s = dump_ready;
  assign dump_valid = 1'b0;
  assign dump_last  = 1'b0;
  assign dump_data  = '0;
  assign dm_r_data  = dm_rdata_s;
`endif

  // FSM, counters and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      drain_q      <= 16'd0;
      host_ready_q <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      host_ready_q <= host_ready_d;
      start_q      <= start_d;
      done_q       <= done_d;
    end
  end

  sync_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_im (
    .clk   (clk),
    .rst   (rst),
    .we    (im_we_s),
    .re    (im_re_s),
    .addr  (im_addr_s),
    .wdata (host_data),
    .rdata (im_rdata_s)
  );

  sync_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dm (
    .clk   (clk),
    .rst   (rst),
    .we    (dm_we_s),
    .re    (dm_re_s),
    .addr  (dm_addr_s),
    .wdata (dm_wdata_s),
    .rdata (dm_rdata_s)
  );

  assign host_ready = host_ready_q;
  assign start      = start_q;
  assign done       = done_q;
  assign im_r_data  = im_rdata_s;

endmodule

// File: tb/tb_ps_mem_responder.sv
// Directed, table-driven bench for ps_mem_responder (with or without PS_MEM_DUMP_EN).
module tb_ps_mem_responder;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_go, host_valid, host_last, stop;
  logic          im_rd, dm_rd, dm_wr, dump_ready;
  logic [AW-1:0] im_addr, dm_addr;
  logic [DW-1:0] host_data, dm_w_data;
  logic          host_ready, start, dump_valid, dump_last, done;
  logic [DW-1:0] im_r_data, dm_r_data, dump_data;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_dm [DEPTH];

  typedef struct {
    logic          im_rd;
    logic [AW-1:0] im_addr;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] exp_im;
    logic [DW-1:0] exp_dm;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  ps_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .host_go(host_go), .host_valid(host_valid),
    .host_ready(host_ready), .host_data(host_data), .host_last(host_last),
    .start(start), .stop(stop), .im_addr(im_addr), .im_rd(im_rd),
    .im_r_data(im_r_data), .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_w_data(dm_w_data), .dm_r_data(dm_r_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
    .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    host_valid = 1'b1;
    host_data  = d;
    host_last  = last;
    tick();
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic stop_and_wait(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`ifdef PS_MEM_DUMP_EN
    check({tag, " drain1 valid"}, dump_valid, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("%s drain%0d valid", tag, k), dump_valid, 1'b0);
    end
    tick();
    check({tag, " first dump_valid"}, dump_valid, 1'b1);
`else
    check({tag, " drain1 done"}, done, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("%s drain%0d done", tag, k), done, 1'b0);
      check($sformatf("%s drain%0d valid", tag, k), dump_valid, 1'b0);
    end
    tick();
    check({tag, " done after drain"}, done, 1'b1);
    check({tag, " valid at done"}, dump_valid, 1'b0);
    tick();
    check({tag, " done held"}, done, 1'b1);
    check({tag, " valid after done"}, dump_valid, 1'b0);
`endif
  endtask

`ifdef PS_MEM_DUMP_EN
  task automatic collect_dump(input string tag, input bit toggle, input bit full);
    int            got = 0;
    int            cyc = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic          pl = 1'b0;
    logic [DW-1:0] pd = '0;
    while (got < DEPTH && cyc < 3000) begin
      if (pv && !pr) begin
        check({tag, " hold valid"}, dump_valid, 1'b1);
        check({tag, " hold data"}, dump_data, pd);
        check({tag, " hold last"}, dump_last, pl);
      end
      dump_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (dump_valid && dump_ready) begin
        if (full || got == 0 || got == 5) begin
          check($sformatf("%s word %0d", tag, got), dump_data, exp_dm[got]);
        end
        check($sformatf("%s last %0d", tag, got), dump_last, got == DEPTH - 1);
        got++;
      end
      pv = dump_valid;
      pr = dump_ready;
      pd = dump_data;
      pl = dump_last;
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    check({tag, " word count"}, got, DEPTH);
    check({tag, " done after last"}, done, 1'b1);
    check({tag, " valid after last"}, dump_valid, 1'b0);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 16'h0000, 16'h2222, 16'h0000};
    vecs[1] = '{1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 16'h0000, 16'h1111, 16'hABCD};
    vecs[2] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 16'h5555, 16'h1111, 16'hABCD};
    vecs[3] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 16'h0000, 16'h1111, 16'h5555};
    vecs[4] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 16'h0F0F, 16'h1111, 16'h5555};
    vecs[5] = '{1'b1, 8'd1, 1'b1, 1'b0, 8'd5, 16'h0000, 16'h2222, 16'h0F0F};
    vecs[6] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0000, 16'h2222, 16'h0F0F};

    rst = 1'b0; host_go = 1'b0; host_valid = 1'b0; host_last = 1'b0; stop = 1'b0;
    im_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; dump_ready = 1'b0;
    im_addr = '0; dm_addr = '0; host_data = '0; dm_w_data = '0;
    tick();
    tick();
    check("rst host_ready", host_ready, 1'b0);
    check("rst start", start, 1'b0);
    check("rst im_r_data", im_r_data, 16'h0000);
    check("rst dm_r_data", dm_r_data, 16'h0000);
    check("rst dump_valid", dump_valid, 1'b0);
    check("rst dump_data", dump_data, 16'h0000);
    check("rst dump_last", dump_last, 1'b0);
    check("rst done", done, 1'b0);
    rst = 1'b1;
    tick();

    // Partial load abandoned by reset in LOAD_DM
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    check("load host_ready", host_ready, 1'b1);
    load_word(16'hDEAD, 1'b0);
    load_word(16'hBEEF, 1'b1);
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    load_word(16'hCCCC, 1'b0);
    check("in LOAD_DM host_ready", host_ready, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst host_ready", host_ready, 1'b0);
    check("midrst start", start, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst dump_valid", dump_valid, 1'b0);
    check("midrst dm_r_data", dm_r_data, 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    check("idle host_ready", host_ready, 1'b0);

    // Run 1: small program, table-driven port accesses
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b1);
    check("no start after IM", start, 1'b0);
    load_word(16'hABCD, 1'b1);
    check("start pulse", start, 1'b1);
    check("ready low in RUN", host_ready, 1'b0);
    for (int i = 0; i < 7; i++) begin
      im_rd = vecs[i].im_rd; im_addr = vecs[i].im_addr;
      dm_rd = vecs[i].dm_rd; dm_wr = vecs[i].dm_wr;
      dm_addr = vecs[i].dm_addr; dm_w_data = vecs[i].dm_wdata;
      tick();
      im_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
      if (i == 0) check("start one cycle", start, 1'b0);
      check($sformatf("vec%0d im_r_data", i), im_r_data, vecs[i].exp_im);
      check($sformatf("vec%0d dm_r_data", i), dm_r_data, vecs[i].exp_dm);
    end
    exp_dm[0] = 16'h5555;
    exp_dm[5] = 16'h0F0F;
    stop_and_wait("run1");
`ifdef PS_MEM_DUMP_EN
    collect_dump("run1 dump", 1'b0, 1'b0);
`endif

    // Run 2: IM wrap-around, full DM image, reads ignored during load
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    check("run2 done low", done, 1'b0);
    check("run2 host_ready", host_ready, 1'b1);
    im_rd = 1'b1; im_addr = 8'd0; dm_rd = 1'b1; dm_addr = 8'd0;
    for (int i = 0; i <= 256; i++) begin
      load_word(16'h1000 + 16'(i), i == 256);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_dm[i] = 16'hC000 ^ {8'(i), 8'(i)};
      load_word(exp_dm[i], i == DEPTH - 1);
    end
    im_rd = 1'b0; dm_rd = 1'b0;
    check("load ignores im_rd", im_r_data, 16'h2222);
    check("load ignores dm_rd", dm_r_data, 16'h0F0F);
    check("run2 start", start, 1'b1);
    im_rd = 1'b1; im_addr = 8'd0;
    tick();
    check("wrap IM[0]", im_r_data, 16'h1100);
    im_addr = 8'd255;
    tick();
    check("IM[255]", im_r_data, 16'h10FF);
    im_addr = 8'd1;
    tick();
    check("IM[1]", im_r_data, 16'h1001);
    im_rd = 1'b0;
    dm_wr = 1'b1; dm_addr = 8'd7; dm_w_data = 16'h7777;
    tick();
    dm_wr = 1'b0;
    exp_dm[7] = 16'h7777;
    dm_rd = 1'b1;
    tick();
    check("DM[7] after write", dm_r_data, 16'h7777);
    dm_addr = 8'd200;
    tick();
    check("DM[200]", dm_r_data, exp_dm[200]);
    dm_rd = 1'b0;
    stop_and_wait("run2");
`ifdef PS_MEM_DUMP_EN
    collect_dump("run2 dump", 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps_mem_responder.md
# ps_mem_responder

Memory-side responder for the 16-bit pipelined processor's instruction-memory and data-memory ports, plus the host sequencer that surrounds a program run. It loads program and data words from a host stream, pulses `start`, and serves the processor's `im_*`/`dm_*` requests with one-cycle read latency. It waits for `stop`, drains in-flight accesses, then streams the full data-memory image back to the host. It sits between the host/testbench stream interface and the processor core.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, memory address width; each memory holds 2^ADDR_WIDTH words
- `DATA_WIDTH`, 16, word width
- `DRAIN_CYCLES`, 4, cycles DM stays serviced after `stop` before the dump begins (≥1)

Ports:
- `clk`  in  1  the single clock
- `rst`  in  1  asynchronous, active-low reset
- `host_go`  in  1  begin a load sequence (sampled in IDLE/DONE)
- `host_valid`  in  1  load word valid
- `host_ready`  out  1  load word accepted when `host_valid && host_ready`
- `host_data`  in  DATA_WIDTH  load word
- `host_last`  in  1  last word of the current phase (IM or DM)
- `start`  out  1  one-cycle start pulse to the processor
- `stop`  in  1  processor stopped flag
- `im_addr`  in  ADDR_WIDTH; `im_rd`  in  1; `im_r_data`  out  DATA_WIDTH
- `dm_addr`  in  ADDR_WIDTH; `dm_rd`  in  1; `dm_wr`  in  1; `dm_w_data`  in  DATA_WIDTH; `dm_r_data`  out  DATA_WIDTH
- `dump_valid`  out  1; `dump_ready`  in  1; `dump_data`  out  DATA_WIDTH; `dump_last`  out  1
- `done`  out  1  sequence complete

## Operation
- FSM states: IDLE, LOAD_IM, LOAD_DM, RUN, DRAIN, DUMP, DONE.
- IDLE/DONE: `host_go` → LOAD_IM, load counter cleared to 0. `done` stays high in DONE and is low elsewhere.
- LOAD_IM/LOAD_DM: `host_ready`=1. Each accepted word is written to IM/DM at the counter, then the counter increments.
  - The counter wraps 2^ADDR_WIDTH-1 → 0 without error.
  - An accepted `host_last` ends the phase: LOAD_IM → LOAD_DM (counter cleared), LOAD_DM → RUN.
- RUN: `start`=1 for exactly the first RUN cycle. Processor ports are serviced only in RUN and DRAIN.
  - Outside RUN/DRAIN, `im_rd`/`dm_rd`/`dm_wr` are ignored.
- `stop` high in RUN → DRAIN, which lasts exactly `DRAIN_CYCLES` cycles → DUMP.
- DUMP: streams DM[0..2^ADDR_WIDTH-1] in order. `dump_last` accompanies the final word. The final handshake → DONE.
- Reads: `im_r_data`/`dm_r_data` register on `*_rd`. With `*_rd` low, each holds its previous value.
- `dm_rd` and `dm_wr` to the same address in the same cycle: the write commits and the read returns the old word (read-before-write).
- Memory contents are not reset. Reset clears only FSM, counters and outputs.
- Reset mid-operation: immediate return to IDLE; any partial load or dump is abandoned.

## Timing
- Reset values: `host_ready`=0, `start`=0, `im_r_data`=0, `dm_r_data`=0, `dump_valid`=0, `dump_data`=0, `dump_last`=0, `done`=0, state IDLE.
- Read latency: address and `*_rd` at edge N → data valid after edge N+1. Data is held until the next read.
- Load: one word per cycle at full throughput. The cycle after the DM `host_last` handshake is the `start` cycle.
- Stop to first `dump_valid`: `DRAIN_CYCLES` + 2 cycles; the extra cycle is the RAM read.
- Dump: `dump_data`/`dump_last` stay stable while `dump_valid && !dump_ready`. Full throughput is one word per cycle with `dump_ready` held high.
- `done` rises the cycle after the final dump handshake.

## Configuration
- `PS_MEM_DUMP_EN` defined: DUMP state and `dump_*` logic are present as described.
- Undefined: DRAIN goes directly to DONE. `dump_valid`, `dump_data` and `dump_last` are tied to 0 and `dump_ready` is ignored.

## Structure
- Package `ps_mem_pkg`: FSM state enum, default `ADDR_WIDTH`/`DATA_WIDTH` constants, memory depth constant.
- Sub-module `sync_ram`: single-port, synchronous-read, read-before-write memory, instantiated for IM and DM.
  - IM port mux: host load in LOAD_IM, processor in RUN/DRAIN.
  - DM port mux: host load in LOAD_DM, processor in RUN/DRAIN, dump reader in DUMP.

## Test plan
- Reset mid-LOAD_DM after 3 words → state IDLE, every output at its reset value; a following `host_go` reloads with the counter at 0.
- Load IM {0x1111, 0x2222 last} and DM {0xABCD last} → `start` pulses one cycle. `im_rd` at addr 1 returns 0x2222 one cycle later; `dm_rd` at addr 0 returns 0xABCD.
- In RUN, `dm_wr` 0x5555 and `dm_rd` to addr 0 in the same cycle → read returns 0xABCD; a read the next cycle returns 0x5555.
- Load 257 IM words with `host_last` on the 257th → IM[0] holds word 257 (wrap-around).
- `stop` raised with `DRAIN_CYCLES`=4 → first `dump_valid` 6 cycles later. With `dump_ready` toggling 1/0, every word is delivered once and in order. `dump_last` is on word 255; `done` rises the next cycle.
- Build without `PS_MEM_DUMP_EN`: `stop` → `done` after exactly 4 DRAIN cycles; `dump_valid` stays 0 throughout.
